// File: rtl/multi_temp_monitor_if.sv
// Bus between the 1 Hz sampling front end and the multi-channel temperature monitor.
// Strobe semantics: tick is a one-cycle qualifier with no back-pressure; temp_in/ch_en are
// only looked at while tick=1, and the outputs change only in the cycle after a tick.
interface multi_temp_monitor_if #(
   parameter int CH = 4,
   parameter int TW = 10
);
   localparam int CW = (CH > 1) ? $clog2(CH) : 1;

   logic              tick;
   logic [CH*TW-1:0]  temp_in;
   logic [CH-1:0]     ch_en;
   logic [CW-1:0]     disp_ch;
   logic [1:0]        disp_mode;
   logic [TW-1:0]     disp_val;
   logic [1:0]        disp_state;
   logic [1:0]        alarm_level;
   logic [CW-1:0]     alarm_ch;

   modport master (
      output tick, temp_in, ch_en,
      input  disp_ch, disp_mode, disp_val, disp_state, alarm_level, alarm_ch
   );

   modport slave (
      input  tick, temp_in, ch_en,
      output disp_ch, disp_mode, disp_val, disp_state, alarm_level, alarm_ch
   );
endinterface

// File: rtl/multi_temp_monitor.sv
// N-channel temperature monitor: per-channel delta/alarm classification with persistence,
// a display sequencer rotating over enabled channels, and a worst-case alarm summary.
module multi_temp_monitor #(
   parameter int CH         = 4,
   parameter int TW         = 10,
   parameter int ATTN_DELTA = 20,
   parameter int EMER_DELTA = 50,
   parameter int PERSIST    = 3,
   parameter int DWELL      = 1
) (
   input logic                 clk,
   input logic                 rst,
   multi_temp_monitor_if.slave mon
);
   localparam int CW = (CH > 1) ? $clog2(CH) : 1;
   localparam int PW = $clog2(PERSIST + 1);
   localparam int DW = $clog2(DWELL + 1);

   localparam logic [1:0] MODE_TEMP  = 2'd0;
   localparam logic [1:0] MODE_DELTA = 2'd1;
   localparam logic [1:0] MODE_STATE = 2'd2;

   localparam logic [1:0] DIR_NONE = 2'd0;
   localparam logic [1:0] DIR_UP   = 2'd1;
   localparam logic [1:0] DIR_DOWN = 2'd2;

   localparam logic [TW-1:0] SAT_MAX  = {1'b0, {(TW-1){1'b1}}};
   localparam logic [TW-1:0] SAT_MIN  = {1'b1, {(TW-1){1'b0}}};
   localparam logic [TW:0]   ATTN_MAG = (TW+1)'(ATTN_DELTA);
   localparam logic [TW:0]   EMER_MAG = (TW+1)'(EMER_DELTA);
   localparam logic [PW-1:0] RUN_END  = PW'(PERSIST - 1);
   localparam logic [DW-1:0] DWELL_END = DW'(DWELL);

   // Per-channel registers and their next values
   logic [TW-1:0] cur_q   [CH];
   logic [TW-1:0] delta_q [CH];
   logic [1:0]    st_q    [CH];
   logic [1:0]    dir_q   [CH];
   logic [PW-1:0] cnt_q   [CH];
   logic [CH-1:0] pv_q;

   logic [TW-1:0] cur_n   [CH];
   logic [TW-1:0] delta_n [CH];
   logic [1:0]    st_n    [CH];
   logic [1:0]    dir_n   [CH];
   logic [PW-1:0] cnt_n   [CH];
   logic [CH-1:0] pv_n;

   logic [TW-1:0] smp;
   logic [TW:0]   diff;
   logic [TW:0]   dext;
   logic [TW:0]   mag;
   logic [1:0]    tgt;
   logic [1:0]    dir;
   logic [PW-1:0] run;

   // Display sequencer state (its mode register is the FSM state)
   logic [CW-1:0] ptr_ch, ptr_ch_n, nxt_en_ch, idx;
   logic [1:0]    ptr_mode, ptr_mode_n;
   logic [DW-1:0] dwell_q, dwell_n;
   logic          any_en, found;

   logic [CW-1:0] disp_ch_n, alarm_ch_n;
   logic [1:0]    disp_mode_n, disp_state_n, alarm_lvl_n;
   logic [TW-1:0] disp_val_n;

   always_comb begin
      smp  = '0;
      diff = '0;
      dext = '0;
      mag  = '0;
      tgt  = 2'd0;
      dir  = DIR_NONE;
      run  = '0;
      pv_n = '0;
      for (int i = 0; i < CH; i++) begin
         cur_n[i]   = '0;
         delta_n[i] = '0;
         st_n[i]    = 2'd0;
         dir_n[i]   = DIR_NONE;
         cnt_n[i]   = '0;
         smp  = mon.temp_in[i*TW +: TW];
         diff = {smp[TW-1], smp} - {cur_q[i][TW-1], cur_q[i]};
         tgt  = 2'd0;
         if (mon.ch_en[i]) begin
            cur_n[i] = smp;
            pv_n[i]  = 1'b1;
            if (pv_q[i]) begin
               // Difference is TW+1 wide; clamp instead of wrapping back into TW bits
               if (diff[TW] != diff[TW-1]) delta_n[i] = diff[TW] ? SAT_MIN : SAT_MAX;
               else                        delta_n[i] = diff[TW-1:0];
            end
            dext = {delta_n[i][TW-1], delta_n[i]};
            mag  = dext[TW] ? (~dext + 1'b1) : dext;
            if (mag >= EMER_MAG)      tgt = 2'd2;
            else if (mag >= ATTN_MAG) tgt = 2'd1;
            dir = (tgt > st_q[i]) ? DIR_UP : (tgt < st_q[i]) ? DIR_DOWN : DIR_NONE;
            dir_n[i] = dir;
            st_n[i]  = st_q[i];
            // A direction change since the last tick restarts the persistence run
            run = (dir == dir_q[i]) ? cnt_q[i] : '0;
            if (dir == DIR_NONE) begin
               cnt_n[i] = '0;
            end else if (tgt == 2'd2 && st_q[i] != 2'd2) begin
               st_n[i]  = 2'd2;
               cnt_n[i] = '0;
            end else if (run == RUN_END) begin
               st_n[i]  = (dir == DIR_UP) ? tgt : st_q[i] - 2'd1;
               cnt_n[i] = '0;
            end else begin
               cnt_n[i] = run + 1'b1;
            end
         end
      end
   end

   // Sequencer next state: advance on every DWELL-th tick, frozen while nothing is enabled
   always_comb begin
      any_en    = |mon.ch_en;
      nxt_en_ch = ptr_ch;
      found     = 1'b0;
      idx       = '0;
      for (int k = 1; k <= CH; k++) begin
         idx = CW'((int'(ptr_ch) + k) % CH);
         if (!found && mon.ch_en[idx]) begin
            nxt_en_ch = idx;
            found     = 1'b1;
         end
      end
      ptr_ch_n   = ptr_ch;
      ptr_mode_n = ptr_mode;
      dwell_n    = dwell_q;
      if (any_en) begin
         if (dwell_q >= DWELL_END) begin
            dwell_n = DW'(1);
            if (!mon.ch_en[ptr_ch] || ptr_mode >= MODE_STATE) begin
               ptr_ch_n   = nxt_en_ch;
               ptr_mode_n = MODE_TEMP;
            end else begin
               ptr_mode_n = ptr_mode + 2'd1;
            end
         end else begin
            dwell_n = dwell_q + 1'b1;
         end
      end
   end

   // Outputs are built from post-tick values so the display never mixes old and new data
   always_comb begin
      disp_ch_n    = '0;
      disp_mode_n  = MODE_TEMP;
      disp_val_n   = '0;
      disp_state_n = 2'd0;
      if (any_en) begin
         disp_ch_n    = ptr_ch_n;
         disp_mode_n  = ptr_mode_n;
         disp_state_n = st_n[ptr_ch_n];
         case (ptr_mode_n)
            MODE_TEMP:  disp_val_n = cur_n[ptr_ch_n];
            MODE_DELTA: disp_val_n = delta_n[ptr_ch_n];
            default:    disp_val_n = '0;
         endcase
      end
      alarm_lvl_n = 2'd0;
      alarm_ch_n  = '0;
      for (int i = 0; i < CH; i++) begin
         if (st_n[i] > alarm_lvl_n) begin
            alarm_lvl_n = st_n[i];
            alarm_ch_n  = CW'(i);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < CH; i++) begin
            cur_q[i]   <= '0;
            delta_q[i] <= '0;
            st_q[i]    <= 2'd0;
            dir_q[i]   <= DIR_NONE;
            cnt_q[i]   <= '0;
         end
         pv_q            <= '0;
         ptr_ch          <= '0;
         ptr_mode        <= MODE_TEMP;
         dwell_q         <= '0;
         mon.disp_ch     <= '0;
         mon.disp_mode   <= MODE_TEMP;
         mon.disp_val    <= '0;
         mon.disp_state  <= 2'd0;
         mon.alarm_level <= 2'd0;
         mon.alarm_ch    <= '0;
      end else if (mon.tick) begin
         for (int i = 0; i < CH; i++) begin
            cur_q[i]   <= cur_n[i];
            delta_q[i] <= delta_n[i];
            st_q[i]    <= st_n[i];
            dir_q[i]   <= dir_n[i];
            cnt_q[i]   <= cnt_n[i];
         end
         pv_q            <= pv_n;
         ptr_ch          <= ptr_ch_n;
         ptr_mode        <= ptr_mode_n;
         dwell_q         <= dwell_n;
         mon.disp_ch     <= disp_ch_n;
         mon.disp_mode   <= disp_mode_n;
         mon.disp_val    <= disp_val_n;
         mon.disp_state  <= disp_state_n;
         mon.alarm_level <= alarm_lvl_n;
         mon.alarm_ch    <= alarm_ch_n;
      end
   end
endmodule

// File: tb/tb_multi_temp_monitor.sv
// Directed bench for multi_temp_monitor (CH=4, TW=10, PERSIST=3, DWELL=1).
module tb_multi_temp_monitor;
   localparam int CH = 4;
   localparam int TW = 10;

   logic clk = 1'b0;
   logic rst;
   int   n_checks = 0;
   int   n_fail   = 0;

   always #5 clk = ~clk;

   multi_temp_monitor_if #(.CH(CH), .TW(TW)) bus ();

   multi_temp_monitor #(
      .CH(CH), .TW(TW), .ATTN_DELTA(20), .EMER_DELTA(50), .PERSIST(3), .DWELL(1)
   ) dut (
      .clk (clk),
      .rst (rst),
      .mon (bus)
   );

   task automatic chk(input string tag, input logic signed [31:0] obs,
                      input logic signed [31:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic check_out(input string tag, input int ch, input int mode, input int val,
                            input int st, input int al, input int ach);
      chk({tag, ".disp_ch"},     bus.disp_ch,              ch);
      chk({tag, ".disp_mode"},   bus.disp_mode,            mode);
      chk({tag, ".disp_val"},    $signed(bus.disp_val),    val);
      chk({tag, ".disp_state"},  bus.disp_state,           st);
      chk({tag, ".alarm_level"}, bus.alarm_level,          al);
      chk({tag, ".alarm_ch"},    bus.alarm_ch,             ach);
   endtask

   // One tick with the given samples; returns at the next falling edge with outputs settled
   task automatic do_tick(input int t0, input int t1, input int t2, input int t3,
                          input logic [3:0] en);
      @(negedge clk);
      bus.temp_in = {TW'(t3), TW'(t2), TW'(t1), TW'(t0)};
      bus.ch_en   = en;
      bus.tick    = 1'b1;
      @(negedge clk);
      bus.tick    = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst         = 1'b1;
      bus.tick    = 1'b0;
      bus.temp_in = '0;
      bus.ch_en   = '0;
      repeat (2) @(negedge clk);
      check_out("reset", 0, 0, 0, 0, 0, 0);
      rst = 1'b0;

      // Steady inputs: delta 0, display walks ch0 TEMP/DELTA/STATE then ch1
      do_tick(250, 250, 250, 250, 4'b1111); check_out("t1",  0, 0, 250, 0, 0, 0);
      do_tick(250, 250, 250, 250, 4'b1111); check_out("t2",  0, 1, 0,   0, 0, 0);
      do_tick(250, 250, 250, 250, 4'b1111); check_out("t3",  0, 2, 0,   0, 0, 0);
      do_tick(250, 250, 250, 250, 4'b1111); check_out("t4",  1, 0, 250, 0, 0, 0);
      do_tick(250, 250, 250, 250, 4'b1111); check_out("t5",  1, 1, 0,   0, 0, 0);

      // ch2 ramps +25 per tick: ATTENTION on the third tick, back to NORMAL after three flat ticks
      do_tick(250, 250, 275, 250, 4'b1111); check_out("t6",  1, 2, 0,   0, 0, 0);
      do_tick(250, 250, 300, 250, 4'b1111); check_out("t7",  2, 0, 300, 0, 0, 0);
      do_tick(250, 250, 325, 250, 4'b1111); check_out("t8",  2, 1, 25,  1, 1, 2);
      do_tick(250, 250, 325, 250, 4'b1111); check_out("t9",  2, 2, 0,   1, 1, 2);
      do_tick(250, 250, 325, 250, 4'b1111); check_out("t10", 3, 0, 250, 0, 1, 2);
      do_tick(250, 250, 325, 250, 4'b1111); check_out("t11", 3, 1, 0,   0, 0, 0);

      // ch1 re-enabled at 200 (delta 0), then jumps +60: immediate EMERGENCY, stepwise recovery
      do_tick(250, 250, 325, 250, 4'b1101); check_out("t12", 3, 2, 0,   0, 0, 0);
      do_tick(250, 200, 325, 250, 4'b1111); check_out("t13", 0, 0, 250, 0, 0, 0);
      do_tick(250, 260, 325, 250, 4'b1111); check_out("t14", 0, 1, 0,   0, 2, 1);
      do_tick(250, 260, 325, 250, 4'b1111); check_out("t15", 0, 2, 0,   0, 2, 1);
      do_tick(250, 260, 325, 250, 4'b1111); check_out("t16", 1, 0, 260, 2, 2, 1);
      do_tick(250, 260, 325, 250, 4'b1111); check_out("t17", 1, 1, 0,   1, 1, 1);
      do_tick(250, 260, 325, 250, 4'b1111); check_out("t18", 1, 2, 0,   1, 1, 1);
      do_tick(250, 260, 325, 250, 4'b1111); check_out("t19", 2, 0, 325, 0, 1, 1);
      do_tick(250, 260, 325, 250, 4'b1111); check_out("t20", 2, 1, 0,   0, 0, 0);

      // ch0 and ch3 both EMERGENCY: tie goes to ch0; disabling ch0 moves it to ch3
      do_tick(310, 260, 325, 190, 4'b1111); check_out("t21", 2, 2, 0,   0, 2, 0);
      do_tick(310, 260, 325, 190, 4'b1110); check_out("t22", 3, 0, 190, 2, 2, 3);
      do_tick(310, 260, 325, 190, 4'b1110); check_out("t23", 3, 1, 0,   2, 2, 3);
      do_tick(310, 260, 325, 190, 4'b1110); check_out("t24", 3, 2, 0,   1, 1, 3);
      do_tick(310, 260, 325, 190, 4'b1110); check_out("t25", 1, 0, 260, 0, 1, 3);

      // Displayed channel disabled: next advance jumps to the next enabled channel
      do_tick(310, 260, 325, 190, 4'b1100); check_out("t26", 2, 0, 325, 0, 1, 3);
      do_tick(310, 500, 325, 190, 4'b1110); check_out("t27", 2, 1, 0,   0, 0, 0);
      repeat (4) do_tick(310, 500, 325, 190, 4'b1110);
      do_tick(310, 500, 325, 190, 4'b1110); check_out("t32", 1, 0, 500, 0, 0, 0);

      // 500 -> -512 must saturate to -512, not wrap positive
      do_tick(310, -512, 325, 190, 4'b1110); check_out("sat", 1, 1, -512, 2, 2, 1);

      // No channel enabled: outputs zero, pointer frozen at ch1 DELTA
      do_tick(310, -512, 325, 190, 4'b0000); check_out("none1", 0, 0, 0, 0, 0, 0);
      do_tick(310, -512, 325, 190, 4'b0000); check_out("none2", 0, 0, 0, 0, 0, 0);

      // Single channel enabled: cycles its own three modes
      do_tick(0, 100, 0, 0, 4'b0010); check_out("one1", 1, 2, 0,   0, 0, 0);
      do_tick(0, 100, 0, 0, 4'b0010); check_out("one2", 1, 0, 100, 0, 0, 0);
      do_tick(0, 100, 0, 0, 4'b0010); check_out("one3", 1, 1, 0,   0, 0, 0);

      // Build up a persistence run on ch2, then reset in a tick cycle
      do_tick(250, 100, 325, 190, 4'b1111); check_out("pre1", 1, 2, 0,   0, 0, 0);
      do_tick(250, 100, 350, 190, 4'b1111); check_out("pre2", 2, 0, 350, 0, 0, 0);
      @(negedge clk);
      bus.temp_in = {TW'(190), TW'(375), TW'(100), TW'(250)};
      bus.ch_en   = 4'b1111;
      bus.tick    = 1'b1;
      rst         = 1'b1;
      @(negedge clk);
      bus.tick    = 1'b0;
      rst         = 1'b0;
      check_out("rst_tick", 0, 0, 0, 0, 0, 0);

      // First tick after reset: large jumps from pre-reset samples must give delta 0
      do_tick(-300, 400, -100, 0, 4'b1111); check_out("post1", 0, 0, -300, 0, 0, 0);
      do_tick(-300, 400, -100, 0, 4'b1111); check_out("post2", 0, 1, 0,    0, 0, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
